// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and width helpers for the conv accumulator
// Purpose: FSM state encoding and the width/geometry derivations used by
//          conv_accum and conv_adder_tree.
// Ports:   none (package).
package conv_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    HOLD    = 2'd2
  } state_e;

  function automatic int unsigned ans_w(input int unsigned w);
    return 2 * w;
  endfunction

  // Sum of fsize products of 2*w bits needs clog2(fsize) guard bits.
  function automatic int unsigned sum_w(input int unsigned w, input int unsigned fsize);
    return 2 * w + $clog2(fsize);
  endfunction

  function automatic int unsigned out_dem_of(input int unsigned in_dem,
                                             input int unsigned f_dem,
                                             input int unsigned st);
    return (in_dem - f_dem) / st + 1;
  endfunction

  // LSB position of slot idx in a flat vector of w-bit slots.
  function automatic int unsigned slot_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// rtl/conv_adder_tree.sv - 2-stage pipelined signed adder tree for one window
// Purpose: reduces ROWS*ROWS signed products to one signed sum. Stage 1
//          registers the per-row sums, stage 2 registers the total. A valid
//          bit travels alongside so input bubbles stay bubbles.
// Ports:   clk, rst        clock, async active-high reset
//          in_valid_i      in_data_i holds a vector to reduce this edge
//          in_data_i       ROWS*ROWS products of IN_W bits, slot k at [k*IN_W +: IN_W]
//          out_valid_o     out_sum_o is a valid window sum
//          out_sum_o       signed SUM_W-bit window sum
module conv_adder_tree #(
  parameter int unsigned ROWS  = 3,
  parameter int unsigned IN_W  = 8,
  parameter int unsigned SUM_W = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid_i,
  input  logic [IN_W*ROWS*ROWS-1:0]    in_data_i,
  output logic                         out_valid_o,
  output logic signed [SUM_W-1:0]      out_sum_o
);

  logic signed [SUM_W-1:0] row_d [ROWS];
  logic signed [SUM_W-1:0] row_q [ROWS];
  logic signed [SUM_W-1:0] sum_d;
  logic signed [SUM_W-1:0] sum_q;
  logic                    v1_q;
  logic                    v2_q;

  // Sign-extend each product to the full sum width before adding.
  always_comb begin
    for (int r = 0; r < int'(ROWS); r++) begin
      row_d[r] = '0;
      for (int c = 0; c < int'(ROWS); c++) begin
        row_d[r] = row_d[r] + SUM_W'($signed(in_data_i[(r*ROWS+c)*IN_W +: IN_W]));
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      sum_d = sum_d + row_q[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      sum_q <= '0;
      for (int r = 0; r < int'(ROWS); r++) row_q[r] <= '0;
    end else begin
      v1_q <= in_valid_i;
      v2_q <= v1_q;
      if (in_valid_i) begin
        for (int r = 0; r < int'(ROWS); r++) row_q[r] <= row_d[r];
      end
      if (v1_q) sum_q <= sum_d;
    end
  end

  assign out_valid_o = v2_q;
  assign out_sum_o   = sum_q;

endmodule

// File: rtl/conv_accum.sv
// rtl/conv_accum.sv - collects window sums into an output feature map
// Purpose: accepts one product vector per output pixel, reduces it through
//          conv_adder_tree and writes the sum into the map slot in row-major
//          order. The full map is offered with a valid/ready handshake.
// Ports:   clk, rst     clock, async active-high reset
//          in_valid     prod holds a window product vector
//          in_ready     vector is accepted on this edge (COLLECT only)
//          prod         filter_size signed products, ans_width bits each
//          out_valid    out_map complete and stable (HOLD)
//          out_ready    downstream takes out_map
//          out_map      out_size signed sums, sum_width bits each
module conv_accum
  import conv_pkg::*;
#(
  parameter int unsigned filter_demension = 3,
  parameter int unsigned input_demension  = 5,
  parameter int unsigned stride           = 1,
  parameter int unsigned width            = 4,
  localparam int unsigned filter_size = filter_demension * filter_demension,
  localparam int unsigned ans_width   = ans_w(width),
  localparam int unsigned out_dem     = out_dem_of(input_demension, filter_demension, stride),
  localparam int unsigned out_size    = out_dem * out_dem,
  localparam int unsigned sum_width   = sum_w(width, filter_size)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ans_width*filter_size-1:0]  prod,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [sum_width*out_size-1:0]     out_map
);

  localparam int unsigned CNT_W = $clog2(out_size + 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]         wr_cnt_q, wr_cnt_d;
  logic [sum_width-1:0]     map_q [out_size];
  logic                     accept;
  logic                     tree_valid;
  logic signed [sum_width-1:0] tree_sum;
  logic                     last_acc;
  logic                     last_wr;

  assign accept   = in_valid & in_ready;
  assign last_acc = (acc_cnt_q == CNT_W'(out_size - 1));
  assign last_wr  = (wr_cnt_q == CNT_W'(out_size - 1));

  conv_adder_tree #(
    .ROWS  (filter_demension),
    .IN_W  (ans_width),
    .SUM_W (sum_width)
  ) u_tree (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (accept),
    .in_data_i   (prod),
    .out_valid_o (tree_valid),
    .out_sum_o   (tree_sum)
  );

  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (tree_valid) wr_cnt_d = wr_cnt_q + 1'b1;
    case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_cnt_d = acc_cnt_q + 1'b1;
          if (last_acc) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tree_valid && last_wr) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        // Slots are left as-is; the next frame overwrites all of them.
        if (out_ready) begin
          state_d   = COLLECT;
          acc_cnt_d = '0;
          wr_cnt_d  = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= COLLECT;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < int'(out_size); p++) map_q[p] <= '0;
    end else begin
      for (int p = 0; p < int'(out_size); p++) begin
        if (tree_valid && (wr_cnt_q == CNT_W'(p))) map_q[p] <= tree_sum;
      end
    end
  end

  for (genvar p = 0; p < int'(out_size); p++) begin : g_map
    assign out_map[slot_lsb(p, sum_width) +: sum_width] = map_q[p];
  end

endmodule

// File: tb/tb_conv_accum.sv
// tb/tb_conv_accum.sv - directed self-checking bench for conv_accum
module tb_conv_accum;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [71:0]  prod;
  logic         out_valid;
  logic         out_ready;
  logic [107:0] out_map;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_map [9];
  logic [71:0] frame_v [9];

  conv_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_map   (out_map)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] vec_all(input int v);
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = v[7:0];
    return r;
  endfunction

  function automatic logic [71:0] vec_first(input int v);
    logic [71:0] r;
    r = '0;
    r[7:0] = v[7:0];
    return r;
  endfunction

  function automatic logic [71:0] vec_ramp(input int p);
    logic [71:0] r;
    int s;
    for (int k = 0; k < 9; k++) begin
      s = p + k - 4;
      r[k*8 +: 8] = s[7:0];
    end
    return r;
  endfunction

  function automatic int vsum(input logic [71:0] v);
    int s;
    s = 0;
    for (int k = 0; k < 9; k++) s += int'($signed(v[k*8 +: 8]));
    return s;
  endfunction

  function automatic int pix(input int p);
    return int'($signed(out_map[p*12 +: 12]));
  endfunction

  task automatic idle();
    prod     = {$urandom, $urandom, $urandom};
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [71:0] v);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) check_eq("push_ready", int'(in_ready), 1);
    prod     = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    prod     = {$urandom, $urandom, $urandom};
  endtask

  task automatic run_frame(input int max_gap);
    for (int p = 0; p < 9; p++) begin
      exp_map[p] = vsum(frame_v[p]);
      push(frame_v[p]);
      if (p != 8) begin
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        for (int i = 0; i < g; i++) idle();
      end
    end
  endtask

  task automatic wait_out(input string tag);
    int t;
    t = 0;
    while (!out_valid && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq(tag, int'(out_valid), 1);
  endtask

  task automatic check_map(input string tag);
    for (int p = 0; p < 9; p++) check_eq($sformatf("%s[%0d]", tag, p), pix(p), exp_map[p]);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("hs_out_valid", int'(out_valid), 0);
    check_eq("hs_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    prod      = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_map_zero", int'(out_map == '0), 1);

    // 1) all ones back-to-back, out_valid exactly 2 cycles after last accept
    for (int p = 0; p < 9; p++) frame_v[p] = vec_all(1);
    run_frame(0);
    check_eq("t1_drain_in_ready", int'(in_ready), 0);
    check_eq("t1_lat0", int'(out_valid), 0);
    @(posedge clk); #1;
    check_eq("t1_lat1", int'(out_valid), 0);
    @(posedge clk); #1;
    check_eq("t1_lat2", int'(out_valid), 1);
    check_map("t1_map");
    handshake();

    // 2) alternating +64 / -56 products
    for (int p = 0; p < 9; p++) frame_v[p] = (p % 2 == 0) ? vec_all(64) : vec_all(-56);
    run_frame(0);
    wait_out("t2_out_valid");
    check_eq("t2_pix0", pix(0), 576);
    check_eq("t2_pix1", pix(1), -504);
    check_map("t2_map");
    handshake();

    // 3) pixel index in slot 0 with random gaps
    for (int p = 0; p < 9; p++) frame_v[p] = vec_first(p);
    run_frame(3);
    wait_out("t3_out_valid");
    check_map("t3_map");

    // 4) hold with out_ready low and in_valid driven for 20 cycles
    for (int i = 0; i < 20; i++) begin
      prod     = vec_all(7);
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (i % 5 == 4) begin
        check_eq($sformatf("t4_in_ready_%0d", i), int'(in_ready), 0);
        check_eq($sformatf("t4_out_valid_%0d", i), int'(out_valid), 1);
      end
    end
    in_valid = 1'b0;
    check_map("t4_map");
    handshake();

    // 6) next frame immediately after the handshake
    for (int p = 0; p < 9; p++) frame_v[p] = vec_ramp(p);
    run_frame(0);
    wait_out("t6_out_valid");
    check_map("t6_map");
    handshake();

    // 5) reset after 5 accepts, then a fresh frame
    for (int p = 0; p < 5; p++) push(vec_all(5));
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("t5_in_ready", int'(in_ready), 1);
    check_eq("t5_out_valid", int'(out_valid), 0);
    check_eq("t5_map_zero", int'(out_map == '0), 1);
    for (int p = 0; p < 9; p++) frame_v[p] = vec_all(p - 4);
    run_frame(2);
    wait_out("t5_out_valid_new");
    check_map("t5_map");
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
